// File: rtl/sort7_frame_collector.sv
`default_nettype none
// ============================================================================
// Module      : sort7_frame_collector
// Description : Upstream feeder for the 7-input sorting network. Collects a
//               valid/ready byte stream into 7-entry frames using two
//               ping-pong buffers. Each complete frame is presented in
//               parallel on o_a..o_g with a valid/ready handshake. A short
//               frame (closed by i_in_last) is padded with PAD_VALUE.
// Ports       : clk, rst            clock, synchronous active-high reset
//               i_in_data/valid/last, o_in_ready   input stream handshake
//               o_a..o_g, o_out_count, o_out_valid, i_out_ready  frame output
// Revision    : 1.0  initial release
// ============================================================================
module sort7_frame_collector #(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] PAD_VALUE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_valid,
    input  logic              i_in_last,
    output logic              o_in_ready,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_b,
    output logic [DATA_W-1:0] o_c,
    output logic [DATA_W-1:0] o_d,
    output logic [DATA_W-1:0] o_e,
    output logic [DATA_W-1:0] o_f,
    output logic [DATA_W-1:0] o_g,
    output logic [2:0]        o_out_count,
    output logic              o_out_valid,
    input  logic              i_out_ready
);

    localparam int       c_NUM_SLOTS = 7;
    localparam logic [2:0] c_LAST_IDX = 3'd6;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } buf_state_t;

    buf_state_t r_state [0:1];
    logic [2:0] r_cnt   [0:1];
    logic       r_wr_sel;       // buffer currently being filled
    logic       r_rd_sel;       // buffer presented on the output (head)
    logic [2:0] r_idx;          // next slot to write in the fill buffer

    logic                                w_in_ready;
    logic                                w_accept;
    logic                                w_close;
    logic                                w_out_valid;
    logic                                w_xfer;
    logic [c_NUM_SLOTS-1:0][DATA_W-1:0]  w_head;

    // Depends only on registered state (plus reset), never on i_out_ready.
    // The fill buffer is full only when both buffers hold complete frames.
    assign w_in_ready  = !rst && (r_state[r_wr_sel] != ST_FULL);
    assign w_accept    = i_in_valid && w_in_ready;
    assign w_close     = w_accept && (i_in_last || (r_idx == c_LAST_IDX));
    assign w_out_valid = (r_state[r_rd_sel] == ST_FULL);
    assign w_xfer      = w_out_valid && i_out_ready;

    // Buffer bookkeeping. A transfer and an accept can never target the same
    // buffer: the head must be FULL to transfer, the fill buffer must not be
    // FULL to accept, so both updates are applied independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state[0] <= ST_EMPTY;
            r_state[1] <= ST_EMPTY;
            r_cnt[0]   <= 3'd0;
            r_cnt[1]   <= 3'd0;
            r_wr_sel   <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_idx      <= 3'd0;
        end else begin
            if (w_xfer) begin
                r_state[r_rd_sel] <= ST_EMPTY;
                r_rd_sel          <= ~r_rd_sel;
            end
            if (w_accept) begin
                if (w_close) begin
                    r_state[r_wr_sel] <= ST_FULL;
                    r_cnt[r_wr_sel]   <= r_idx + 3'd1;
                    r_wr_sel          <= ~r_wr_sel;
                    r_idx             <= 3'd0;
                end else begin
                    r_state[r_wr_sel] <= ST_FILLING;
                    r_idx             <= r_idx + 3'd1;
                end
            end
        end
    end

    // Per-slot storage for both buffers. On close, every slot above the
    // closing index is overwritten with the pad value so stale bytes from an
    // earlier frame never leak into a short frame.
    for (genvar s = 0; s < c_NUM_SLOTS; s++) begin : g_slot
        logic [DATA_W-1:0] r_slot [0:1];

        always_ff @(posedge clk) begin
            if (w_accept) begin
                if (r_idx == 3'(s)) begin
                    r_slot[r_wr_sel] <= i_in_data;
                end else if (w_close && (r_idx < 3'(s))) begin
                    r_slot[r_wr_sel] <= PAD_VALUE;
                end
            end
        end

        assign w_head[s] = w_out_valid ? r_slot[r_rd_sel] : PAD_VALUE;
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_out_count = w_out_valid ? r_cnt[r_rd_sel] : 3'd0;
    assign o_a         = w_head[0];
    assign o_b         = w_head[1];
    assign o_c         = w_head[2];
    assign o_d         = w_head[3];
    assign o_e         = w_head[4];
    assign o_f         = w_head[5];
    assign o_g         = w_head[6];

endmodule
`default_nettype wire
